// File: rtl/irq_arbiter.sv
// Interrupt arbiter: latches edge/level requests, masks them, and hands one line at a time to the core
// through an irq_req/irq_ack/irq_done handshake. Lowest index has the highest priority; there is no nesting.
module irq_arbiter #(
  parameter int              NIRQ      = 8,
  parameter int              VECW      = 3,
  parameter logic [NIRQ-1:0] EDGE_MASK = 8'hFF
) (
  input  logic            ph1,
  input  logic            reset_b,
  input  logic [NIRQ-1:0] interrupts,
  input  logic            mask_we,
  input  logic [NIRQ-1:0] mask_wdata,
  output logic [NIRQ-1:0] mask_q,
  input  logic            clr_we,
  input  logic [NIRQ-1:0] clr_wdata,
  output logic [NIRQ-1:0] pending,
  output logic [NIRQ-1:0] overrun,
  output logic            irq_req,
  output logic [VECW-1:0] irq_vec,
  input  logic            irq_ack,
  input  logic            irq_done,
  output logic            in_service
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [NIRQ-1:0] prev_q, prev_d;
  logic [NIRQ-1:0] pending_q, pending_d;
  logic [NIRQ-1:0] overrun_q, overrun_d;
  logic [NIRQ-1:0] mask_d;
  logic            irq_req_q, irq_req_d;
  logic [VECW-1:0] irq_vec_q, irq_vec_d;
  logic            in_service_q, in_service_d;

  logic [NIRQ-1:0] rise;
  logic [NIRQ-1:0] eligible;
  logic [NIRQ-1:0] sw_clr;
  logic [NIRQ-1:0] ack_clr;
  logic [NIRQ-1:0] edge_pend;
  logic [VECW-1:0] winner;
  logic            ack_hit;

  always_comb begin
    rise     = interrupts & ~prev_q;
    eligible = pending_q & mask_q;
    ack_hit  = (state_q == REQ) && irq_ack;
    sw_clr   = clr_we ? clr_wdata : '0;
    ack_clr  = ack_hit ? (NIRQ'(1) << irq_vec_q) : '0;

    winner = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (eligible[i]) winner = VECW'(i);
    end

    // A rise in the same cycle as any clear survives, so no edge is lost.
    edge_pend = (pending_q & ~(sw_clr | ack_clr)) | rise;
    pending_d = (edge_pend & EDGE_MASK) | (interrupts & ~EDGE_MASK);
    overrun_d = ((overrun_q & ~sw_clr) | (rise & pending_q)) & EDGE_MASK;
    prev_d    = interrupts;
    mask_d    = mask_we ? mask_wdata : mask_q;

    state_d      = state_q;
    irq_req_d    = irq_req_q;
    irq_vec_d    = irq_vec_q;
    in_service_d = in_service_q;
    case (state_q)
      IDLE: begin
        if (eligible != '0) begin
          irq_vec_d = winner;
          irq_req_d = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (irq_ack) begin
          irq_req_d    = 1'b0;
          in_service_d = 1'b1;
          state_d      = SERVICE;
        end else if (!eligible[irq_vec_q]) begin
          irq_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      SERVICE: begin
        if (irq_done) begin
          in_service_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        irq_req_d    = 1'b0;
        in_service_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  always_ff @(posedge ph1 or negedge reset_b) begin
    if (!reset_b) begin
      state_q      <= IDLE;
      prev_q       <= '1;
      pending_q    <= '0;
      overrun_q    <= '0;
      mask_q       <= '0;
      irq_req_q    <= 1'b0;
      irq_vec_q    <= '0;
      in_service_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      mask_q       <= mask_d;
      irq_req_q    <= irq_req_d;
      irq_vec_q    <= irq_vec_d;
      in_service_q <= in_service_d;
    end
  end

  assign pending    = pending_q;
  assign overrun    = overrun_q;
  assign irq_req    = irq_req_q;
  assign irq_vec    = irq_vec_q;
  assign in_service = in_service_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter: an all-edge instance and a mixed instance (line 0 level-sensitive).
module tb_irq_arbiter;

  logic       ph1 = 1'b0;
  logic       reset_b;

  logic [7:0] interrupts, mask_wdata, clr_wdata;
  logic       mask_we, clr_we, irq_ack, irq_done;
  logic [7:0] mask_q, pending, overrun;
  logic       irq_req, in_service;
  logic [2:0] irq_vec;

  logic [7:0] l_interrupts, l_mask_wdata, l_clr_wdata;
  logic       l_mask_we, l_clr_we, l_irq_ack, l_irq_done;
  logic [7:0] l_mask_q, l_pending, l_overrun;
  logic       l_irq_req, l_in_service;
  logic [2:0] l_irq_vec;

  int tests = 0;
  int fails = 0;

  always #5 ph1 = ~ph1;

  irq_arbiter dut (
    .ph1(ph1), .reset_b(reset_b), .interrupts(interrupts),
    .mask_we(mask_we), .mask_wdata(mask_wdata), .mask_q(mask_q),
    .clr_we(clr_we), .clr_wdata(clr_wdata), .pending(pending), .overrun(overrun),
    .irq_req(irq_req), .irq_vec(irq_vec), .irq_ack(irq_ack), .irq_done(irq_done),
    .in_service(in_service)
  );

  irq_arbiter #(.NIRQ(8), .VECW(3), .EDGE_MASK(8'hFE)) dut_lvl (
    .ph1(ph1), .reset_b(reset_b), .interrupts(l_interrupts),
    .mask_we(l_mask_we), .mask_wdata(l_mask_wdata), .mask_q(l_mask_q),
    .clr_we(l_clr_we), .clr_wdata(l_clr_wdata), .pending(l_pending), .overrun(l_overrun),
    .irq_req(l_irq_req), .irq_vec(l_irq_vec), .irq_ack(l_irq_ack), .irq_done(l_irq_done),
    .in_service(l_in_service)
  );

  task automatic tick();
    @(posedge ph1);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [7:0] lines);
    interrupts = lines;
    tick();
    interrupts = 8'h00;
  endtask

  task automatic write_mask(input logic [7:0] m);
    mask_we    = 1'b1;
    mask_wdata = m;
    tick();
    mask_we    = 1'b0;
  endtask

  task automatic do_ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic do_done();
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
  endtask

  initial begin
    reset_b = 1'b0;
    interrupts = 8'h00; mask_we = 1'b0; mask_wdata = 8'h00; clr_we = 1'b0; clr_wdata = 8'h00;
    irq_ack = 1'b0; irq_done = 1'b0;
    l_interrupts = 8'h00; l_mask_we = 1'b0; l_mask_wdata = 8'h00; l_clr_we = 1'b0;
    l_clr_wdata = 8'h00; l_irq_ack = 1'b0; l_irq_done = 1'b0;
    #12;
    chk("rst_pending", pending, 8'h00);
    chk("rst_mask", mask_q, 8'h00);
    chk("rst_req", irq_req, 1'b0);
    chk("rst_vec", irq_vec, 3'd0);
    chk("rst_insvc", in_service, 1'b0);
    chk("rst_l_pending", l_pending, 8'h00);
    tick();
    reset_b = 1'b1;
    tick();

    // 1: single-cycle pulse on line 0
    write_mask(8'h03);
    chk("t1_mask", mask_q, 8'h03);
    pulse(8'h01);
    chk("t1_pend_n", pending, 8'h01);
    chk("t1_req_n", irq_req, 1'b0);
    tick();
    chk("t1_req_n1", irq_req, 1'b1);
    chk("t1_vec_n1", irq_vec, 3'd0);
    do_ack();
    chk("t1_ack_req", irq_req, 1'b0);
    chk("t1_ack_pend", pending, 8'h00);
    chk("t1_ack_insvc", in_service, 1'b1);
    do_done();
    chk("t1_done_insvc", in_service, 1'b0);
    tick();
    chk("t1_done_req", irq_req, 1'b0);

    // 2: simultaneous pulses, priority then one IDLE cycle
    pulse(8'h03);
    chk("t2_pend", pending, 8'h03);
    tick();
    chk("t2_vec0", irq_vec, 3'd0);
    chk("t2_req0", irq_req, 1'b1);
    do_ack();
    chk("t2_pend_after_ack", pending, 8'h02);
    do_done();
    chk("t2_idle_gap", irq_req, 1'b0);
    tick();
    chk("t2_req1", irq_req, 1'b1);
    chk("t2_vec1", irq_vec, 3'd1);
    do_ack();
    do_done();
    chk("t2_pend_end", pending, 8'h00);

    // 3: repeated edges on line 1 while line 0 is in service
    pulse(8'h01);
    tick();
    do_ack();
    chk("t3_svc0", in_service, 1'b1);
    write_mask(8'h02);
    pulse(8'h02);
    chk("t3_pend1", pending, 8'h02);
    chk("t3_ovr_first", overrun, 8'h00);
    repeat (8) tick();
    pulse(8'h02);
    chk("t3_ovr_set", overrun, 8'h02);
    repeat (23) tick();
    pulse(8'h02);
    chk("t3_still_svc", in_service, 1'b1);
    chk("t3_no_req_svc", irq_req, 1'b0);
    do_done();
    chk("t3_gap", irq_req, 1'b0);
    tick();
    chk("t3_req", irq_req, 1'b1);
    chk("t3_vec", irq_vec, 3'd1);
    do_ack();
    chk("t3_pend_clr", pending, 8'h00);
    chk("t3_ovr_kept", overrun, 8'h02);
    do_done();
    tick();
    tick();
    chk("t3_single_req", irq_req, 1'b0);
    clr_we = 1'b1; clr_wdata = 8'h02;
    tick();
    clr_we = 1'b0; clr_wdata = 8'h00;
    chk("t3_ovr_clr", overrun, 8'h00);

    // 4: mask withdrawal while requesting
    pulse(8'h02);
    tick();
    chk("t4_req", irq_req, 1'b1);
    chk("t4_vec", irq_vec, 3'd1);
    write_mask(8'h00);
    chk("t4_req_mask_edge", irq_req, 1'b1);
    tick();
    chk("t4_withdrawn", irq_req, 1'b0);
    chk("t4_pend_kept", pending, 8'h02);
    chk("t4_no_svc", in_service, 1'b0);
    write_mask(8'h02);
    tick();
    chk("t4_rereq", irq_req, 1'b1);

    // 5: asynchronous reset mid-service
    do_ack();
    chk("t5_svc", in_service, 1'b1);
    interrupts = 8'h04;
    tick();
    chk("t5_pend2", pending, 8'h04);
    #3;
    reset_b = 1'b0;
    #1;
    chk("t5_async_insvc", in_service, 1'b0);
    chk("t5_async_pend", pending, 8'h00);
    chk("t5_async_mask", mask_q, 8'h00);
    chk("t5_async_req", irq_req, 1'b0);
    chk("t5_async_vec", irq_vec, 3'd0);
    tick();
    reset_b = 1'b1;
    tick();
    tick();
    chk("t5_no_edge", pending, 8'h00);
    chk("t5_no_ovr", overrun, 8'h00);
    interrupts = 8'h00;

    // 6: level-sensitive line 0 on the mixed instance
    l_mask_we = 1'b1; l_mask_wdata = 8'h01;
    tick();
    l_mask_we = 1'b0;
    l_interrupts = 8'h01;
    tick();
    chk("t6_pend", l_pending, 8'h01);
    tick();
    chk("t6_req", l_irq_req, 1'b1);
    chk("t6_vec", l_irq_vec, 3'd0);
    l_irq_ack = 1'b1;
    tick();
    l_irq_ack = 1'b0;
    chk("t6_svc", l_in_service, 1'b1);
    chk("t6_pend_ack", l_pending, 8'h01);
    l_irq_done = 1'b1;
    tick();
    l_irq_done = 1'b0;
    chk("t6_done", l_in_service, 1'b0);
    tick();
    chk("t6_rereq", l_irq_req, 1'b1);
    l_interrupts = 8'h00;
    tick();
    chk("t6_pend_fall", l_pending, 8'h00);
    chk("t6_ovr", l_overrun, 8'h00);
    tick();
    chk("t6_withdrawn", l_irq_req, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
